// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: arbitrates ARP, RST_ACK and round-robin UDP frames onto one tx engine
module eth_tx_scheduler #(
    parameter int N_CH            = 4,
    parameter int CH_W            = 2,
    parameter int IFG_CYCLES      = 12,
    parameter int WATCH_DOG_WIDTH = 12
) (
    input  logic            clk_125m,
    input  logic            sys_rst_n,
    input  logic            trig_arp,
    input  logic            trig_package_rst,
    input  logic [N_CH-1:0] udp_req,
    output logic [N_CH-1:0] udp_grant,
    input  logic            tx_ready,
    output logic            tx_start,
    output logic [1:0]      tx_kind,
    output logic [CH_W-1:0] tx_chan,
    input  logic            tx_done,
    output logic            tx_busy,
    output logic            arp_pending,
    output logic            rst_pending,
    output logic            timeout_err
);

    localparam int GAP_N = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int GAP_W = $clog2(GAP_N + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N - 1);
    localparam logic [WATCH_DOG_WIDTH-1:0] WD_LAST = {{(WATCH_DOG_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [N_CH-1:0] ONE = N_CH'(1);
    localparam logic [1:0] KIND_UDP = 2'd0;
    localparam logic [1:0] KIND_ARP = 2'd1;
    localparam logic [1:0] KIND_RST = 2'd2;

    typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

    state_t                     state;
    logic [CH_W-1:0]            rr_ptr;
    logic [CH_W-1:0]            udp_sel;
    logic [CH_W-1:0]            idx;
    logic                       udp_any;
    logic [WATCH_DOG_WIDTH-1:0] wd;
    logic [GAP_W-1:0]           gap_cnt;
    logic                       go;
    logic                       sel_arp;
    logic                       sel_rst;

    // A trig pulse defers the IDLE decision one cycle so the newly latched request can compete
    assign go      = (state == IDLE) && tx_ready && !trig_arp && !trig_package_rst &&
                     (arp_pending || rst_pending || udp_any);
    assign sel_arp = go && arp_pending;
    assign sel_rst = go && !arp_pending && rst_pending;

    // Round-robin search for the first requesting channel after the last granted one
    always_comb begin
        udp_any = 1'b0;
        udp_sel = '0;
        idx     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % N_CH);
            if (!udp_any && udp_req[idx]) begin
                udp_any = 1'b1;
                udp_sel = idx;
            end
        end
    end

    // Pending flags: a trig in the clearing cycle keeps the flag set
    always_ff @(posedge clk_125m) begin
        if (!sys_rst_n) begin
            arp_pending <= 1'b0;
            rst_pending <= 1'b0;
        end else begin
            arp_pending <= trig_arp || (arp_pending && !sel_arp);
            rst_pending <= trig_package_rst || (rst_pending && !sel_rst);
        end
    end

    // Frame sequencing FSM with registered outputs, watchdog and inter-frame gap
    always_ff @(posedge clk_125m) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_kind     <= KIND_UDP;
            tx_chan     <= '0;
            udp_grant   <= '0;
            tx_busy     <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= CH_W'(N_CH - 1);
            wd          <= '0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state     <= START;
                    tx_start  <= 1'b1;
                    tx_busy   <= 1'b1;
                    tx_kind   <= arp_pending ? KIND_ARP : rst_pending ? KIND_RST : KIND_UDP;
                    tx_chan   <= (arp_pending || rst_pending) ? '0 : udp_sel;
                    udp_grant <= (arp_pending || rst_pending) ? '0 : ONE << udp_sel;
                end
                START: begin
                    state    <= BUSY;
                    tx_start <= 1'b0;
                    wd       <= '0;
                    if (tx_kind == KIND_UDP) rr_ptr <= tx_chan;
                end
                BUSY: if (tx_done || wd == WD_LAST) begin
                    state       <= GAP;
                    timeout_err <= !tx_done;
                    udp_grant   <= '0;
                    tx_kind     <= KIND_UDP;
                    tx_chan     <= '0;
                    gap_cnt     <= '0;
                end else begin
                    wd <= wd + WATCH_DOG_WIDTH'(1);
                end
                GAP: begin
                    timeout_err <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
